// File: rtl/sketch_tuple_queue_if.sv
// sketch_tuple_queue_if: every non-clock/reset signal of sketch_tuple_queue in one bundle.
// Modports: slave = the queue block, master = the environment around it.
// Signals:
//   din/din_valid/din_empty/din_rd           cropped beat source and its read enable
//   tuser/tuser_valid/tuser_empty/tuser_rd   packet sideband source and its read enable
//   upd_valid/upd_ready/upd_tuple/upd_bytes/upd_key/upd_sram_id   tuple update handshake
//   rd_req/rd_addr/rd_valid/rd_ready/rd_key  register-read request and handshake
//   drop_cnt/runt_cnt                        saturating event counters
//   state                                    arbiter state (0 IDLE, 1 UPDATE, 2 REG_READ)
interface sketch_tuple_queue_if #(
    parameter int DATA_WIDTH  = 201,
    parameter int TUSER_WIDTH = 128,
    parameter int ADDR_WIDTH  = 19,
    parameter int CNT_WIDTH   = 16
);
    logic [DATA_WIDTH-1:0]  din;
    logic                   din_valid;
    logic                   din_empty;
    logic                   din_rd;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tuser_valid;
    logic                   tuser_empty;
    logic                   tuser_rd;
    logic                   upd_valid;
    logic                   upd_ready;
    logic [103:0]           upd_tuple;
    logic [15:0]            upd_bytes;
    logic [31:0]            upd_key;
    logic [15:0]            upd_sram_id;
    logic                   rd_req;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [31:0]            rd_key;
    logic [CNT_WIDTH-1:0]   drop_cnt;
    logic [CNT_WIDTH-1:0]   runt_cnt;
    logic [1:0]             state;
    modport slave (
        input  din, din_valid, din_empty, tuser, tuser_valid, tuser_empty,
               upd_ready, rd_req, rd_addr, rd_ready,
        output din_rd, tuser_rd, upd_valid, upd_tuple, upd_bytes, upd_key, upd_sram_id,
               rd_valid, rd_key, drop_cnt, runt_cnt, state
    );
    modport master (
        output din, din_valid, din_empty, tuser, tuser_valid, tuser_empty,
               upd_ready, rd_req, rd_addr, rd_ready,
        input  din_rd, tuser_rd, upd_valid, upd_tuple, upd_bytes, upd_key, upd_sram_id,
               rd_valid, rd_key, drop_cnt, runt_cnt, state
    );
endinterface

// File: rtl/sketch_tuple_queue.sv
// sketch_tuple_queue: extracts a 5-tuple + byte count from cropped packet beats, queues
// it, and arbitrates between sketch updates and register reads.
// Ports:
//   memclk   clock, all logic on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      sketch_tuple_queue_if.slave (beat/sideband sources, update and read handshakes,
//            drop/runt counters, arbiter state)
// Build option: define SKETCH_IPV4_FILTER_EN to queue only packets with eth_type 0x0800.
module sketch_tuple_queue #(
    parameter int DATA_WIDTH  = 201,
    parameter int TUSER_WIDTH = 128,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_WIDTH  = 19,
    parameter int CNT_WIDTH   = 16
) (
    input logic                 memclk,
    input logic                 reset_n,
    sketch_tuple_queue_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 120;
    typedef enum logic [1:0] {IDLE = 2'd0, UPDATE = 2'd1, REG_READ = 2'd2} state_t;
    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_beat;
    logic [31:0]           r_src_ip;
    logic [31:0]           r_dst_ip;
    logic [15:0]           r_sport;
    logic [15:0]           r_dport;
    logic [15:0]           r_bytes;
    logic [7:0]            r_proto;
    logic                  r_push;
    logic [EW-1:0]         r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [PW:0]           r_count;
    logic                  r_pend;
    logic                  r_last_rd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_drop;
    logic [CNT_WIDTH-1:0]  r_runt;
    logic                  w_last;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push_ok;
    logic                  w_drop;
    logic                  w_avail;
    logic                  w_pass;
    logic [EW-1:0]         w_ent;
    logic [31:0]           w_key;

    assign bus.din_rd   = bus.din_valid & ~bus.din_empty;
    assign bus.tuser_rd = bus.tuser_valid & ~bus.tuser_empty;
    assign w_last       = bus.din_valid & bus.din[1];

`ifdef SKETCH_IPV4_FILTER_EN
    logic [15:0] r_eth;
    always_ff @(posedge memclk or negedge reset_n)
        if (!reset_n)
            r_eth <= '0;
        else if (bus.din_valid && r_beat == 2'd0)
            r_eth <= {bus.din[112:105], bus.din[120:113]};
    assign w_pass = r_eth == 16'h0800;
`else
    assign w_pass = 1'b1;
`endif

    // Beat parsing; the tuple is complete when the last beat is accepted, so the push
    // request is a one-cycle registered pulse after it.
    always_ff @(posedge memclk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat   <= '0;
            r_push   <= 1'b0;
            r_src_ip <= '0;
            r_dst_ip <= '0;
            r_sport  <= '0;
            r_dport  <= '0;
            r_bytes  <= '0;
            r_proto  <= '0;
            r_runt   <= '0;
            r_drop   <= '0;
        end else begin
            r_push <= w_last && r_beat != 2'd0 && w_pass;
            if (bus.din_valid)
                r_beat <= bus.din[1] ? 2'd0 : (r_beat == 2'd2 ? 2'd2 : r_beat + 2'd1);
            if (bus.din_valid && r_beat == 2'd0) begin
                r_proto <= {bus.din[196:193], bus.din[200:197]};
                r_sport <= bus.tuser[47:32];
                r_dport <= bus.tuser[63:48];
                r_bytes <= bus.tuser[15:0];
            end
            if (bus.din_valid && r_beat == 2'd1) begin
                r_src_ip <= {bus.din[32:25], bus.din[40:33], bus.din[48:41], bus.din[56:49]};
                r_dst_ip <= {bus.din[64:57], bus.din[72:65], bus.din[80:73], bus.din[88:81]};
            end
            if (w_last && r_beat == 2'd0 && r_runt != '1)
                r_runt <= r_runt + 1'b1;
            if (w_drop && r_drop != '1)
                r_drop <= r_drop + 1'b1;
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign w_full    = r_count == (PW+1)'(FIFO_DEPTH);
    assign w_pop     = r_state == UPDATE && bus.upd_ready;
    assign w_push_ok = r_push && (!w_full || w_pop);
    assign w_drop    = r_push && w_full && !w_pop;
    // Counting the in-flight push lets the arbiter grant UPDATE one cycle earlier.
    assign w_avail   = r_count != '0 || w_push_ok;

    always_ff @(posedge memclk)
        if (w_push_ok)
            r_mem[r_wptr] <= {r_src_ip, r_dst_ip, r_sport, r_dport, r_proto, r_bytes};

    always_ff @(posedge memclk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (PW+1)'(w_push_ok) - (PW+1)'(w_pop);
        end
    end

    // A request arriving in the same cycle the previous one completes stays pending.
    always_ff @(posedge memclk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend    <= 1'b0;
            r_addr    <= '0;
            r_last_rd <= 1'b0;
        end else begin
            if (r_state == REG_READ && bus.rd_ready)
                r_pend <= 1'b0;
            if (bus.rd_req) begin
                r_pend <= 1'b1;
                r_addr <= bus.rd_addr;
            end
            if (r_state == IDLE && w_next != IDLE)
                r_last_rd <= w_next == REG_READ;
        end
    end

    always_ff @(posedge memclk or negedge reset_n)
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_avail && (!r_pend || r_last_rd) ? UPDATE : (r_pend ? REG_READ : IDLE);
            UPDATE:   w_next = bus.upd_ready ? IDLE : UPDATE;
            REG_READ: w_next = bus.rd_ready ? IDLE : REG_READ;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_ent           = r_state == UPDATE ? r_mem[r_rptr] : '0;
        w_key           = w_ent[119:88] | w_ent[87:56];
        bus.upd_valid   = r_state == UPDATE;
        bus.rd_valid    = r_state == REG_READ;
        bus.upd_tuple   = w_ent[119:16];
        bus.upd_bytes   = w_ent[15:0];
        bus.upd_key     = w_key;
        bus.upd_sram_id = w_key[15:0];
        bus.rd_key      = r_state == REG_READ ? 32'(r_addr) : '0;
        bus.drop_cnt    = r_drop;
        bus.runt_cnt    = r_runt;
        bus.state       = r_state;
    end
endmodule

// File: tb/tb_sketch_tuple_queue.sv
// tb_sketch_tuple_queue: directed vectors for sketch_tuple_queue with hand-computed
// expectations; counters are narrowed to 3 bits so saturation is reachable quickly.
module tb_sketch_tuple_queue;
    localparam int CW = 3;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    sketch_tuple_queue_if #(.CNT_WIDTH(CW)) bus ();
    sketch_tuple_queue #(.CNT_WIDTH(CW)) dut (.memclk(clk), .reset_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input int nb, input logic [15:0] eth, input logic [7:0] pr,
                            input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] by);
        logic [200:0] d;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            if (b == 0) begin
                d[112:105] = eth[15:8];
                d[120:113] = eth[7:0];
                d[196:193] = pr[7:4];
                d[200:197] = pr[3:0];
                bus.tuser = '0;
                bus.tuser[15:0] = by;
                bus.tuser[47:32] = sp;
                bus.tuser[63:48] = dp;
            end else if (b == 1) begin
                d[32:25] = src[31:24];
                d[40:33] = src[23:16];
                d[48:41] = src[15:8];
                d[56:49] = src[7:0];
                d[64:57] = dst[31:24];
                d[72:65] = dst[23:16];
                d[80:73] = dst[15:8];
                d[88:81] = dst[7:0];
            end
            d[1] = (b == nb - 1);
            bus.din = d;
            bus.din_valid = 1'b1;
            bus.din_empty = 1'b0;
            bus.tuser_valid = (b == 0);
            bus.tuser_empty = 1'b0;
            tick();
        end
        bus.din_valid = 1'b0;
        bus.din_empty = 1'b1;
        bus.tuser_valid = 1'b0;
        bus.tuser_empty = 1'b1;
    endtask

    task automatic wait_upd(input string tag);
        int n = 0;
        while (!bus.upd_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".valid"}, bus.upd_valid, 1);
    endtask

    task automatic take_upd(input string tag, input logic [15:0] by);
        wait_upd(tag);
        chk({tag, ".bytes"}, bus.upd_bytes, by);
        bus.upd_ready = 1'b1;
        tick();
        bus.upd_ready = 1'b0;
    endtask

    initial begin
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.din_empty = 1'b1;
        bus.tuser = '0;
        bus.tuser_valid = 1'b0;
        bus.tuser_empty = 1'b1;
        bus.upd_ready = 1'b0;
        bus.rd_req = 1'b0;
        bus.rd_addr = '0;
        bus.rd_ready = 1'b0;
        tick(2);
        chk("rst.state", bus.state, 0);
        chk("rst.upd_valid", bus.upd_valid, 0);
        chk("rst.rd_valid", bus.rd_valid, 0);
        chk("rst.drop", bus.drop_cnt, 0);
        chk("rst.runt", bus.runt_cnt, 0);
        chk("rst.tuple", bus.upd_tuple, 0);
        bus.din_valid = 1'b1;
        bus.din_empty = 1'b0;
        #1 chk("din_rd.on", bus.din_rd, 1);
        bus.din_empty = 1'b1;
        #1 chk("din_rd.empty", bus.din_rd, 0);
        bus.din_valid = 1'b0;
        bus.tuser_valid = 1'b1;
        bus.tuser_empty = 1'b0;
        #1 chk("tuser_rd.on", bus.tuser_rd, 1);
        bus.tuser_valid = 1'b0;
        #1 chk("tuser_rd.novalid", bus.tuser_rd, 0);
        bus.tuser_empty = 1'b1;
        rst_n = 1'b1;
        tick(2);

        // basic two-beat packet and t+2 latency
        send_pkt(2, 16'h0800, 8'd6, 32'h0A000001, 32'h0A000002, 16'd80, 16'd443, 16'h0040);
        chk("lat.t1", bus.upd_valid, 0);
        tick();
        chk("lat.t2", bus.upd_valid, 1);
        chk("t1.tuple", bus.upd_tuple, {32'h0A000001, 32'h0A000002, 16'd80, 16'd443, 8'd6});
        chk("t1.bytes", bus.upd_bytes, 16'h0040);
        chk("t1.key", bus.upd_key, 32'h0A000003);
        chk("t1.sram", bus.upd_sram_id, 16'h0003);
        tick();
        chk("t1.hold", bus.upd_valid, 1);
        chk("t1.hold_tuple", bus.upd_tuple, {32'h0A000001, 32'h0A000002, 16'd80, 16'd443, 8'd6});
        bus.upd_ready = 1'b1;
        tick();
        bus.upd_ready = 1'b0;
        chk("t1.after_hs", bus.upd_valid, 0);
        tick(3);
        chk("t1.single", bus.upd_valid, 0);

        // runt packet
        send_pkt(1, 16'h0800, 8'd6, 32'h1, 32'h2, 16'd3, 16'd4, 16'd5);
        chk("runt.cnt", bus.runt_cnt, 1);
        tick(3);
        chk("runt.noupd", bus.upd_valid, 0);

        // overflow: six pushes into a depth-4 queue with ready low
        for (int i = 1; i <= 6; i++)
            send_pkt(2, 16'h0800, 8'd17, 32'(i), 32'h0, 16'd1, 16'd2, 16'(i));
        tick(2);
        chk("ovf.drop", bus.drop_cnt, 2);
        chk("ovf.head", bus.upd_bytes, 1);
        for (int i = 1; i <= 4; i++)
            take_upd($sformatf("ovf%0d", i), 16'(i));
        tick(4);
        chk("ovf.empty", bus.upd_valid, 0);

        // arbitration with both sources waiting; second rd_req overwrites the address
        send_pkt(2, 16'h0800, 8'd6, 32'h1, 32'h2, 16'd3, 16'd4, 16'h00A1);
        tick();
        chk("arb.upd0", bus.state, 1);
        bus.rd_addr = 19'h11111;
        bus.rd_req = 1'b1;
        tick();
        bus.rd_addr = 19'h12345;
        tick();
        bus.rd_req = 1'b0;
        send_pkt(2, 16'h0800, 8'd6, 32'h1, 32'h2, 16'd3, 16'd4, 16'h00B2);
        tick();
        chk("arb.hold", bus.state, 1);
        chk("arb.hold_rd", bus.rd_valid, 0);
        chk("arb.hold_bytes", bus.upd_bytes, 16'h00A1);
        bus.upd_ready = 1'b1;
        tick();
        bus.upd_ready = 1'b0;
        chk("arb.idle0", bus.state, 0);
        tick();
        chk("arb.rd", bus.state, 2);
        chk("arb.rd_valid", bus.rd_valid, 1);
        chk("arb.rd_key", bus.rd_key, 32'h00012345);
        chk("arb.rd_noupd", bus.upd_valid, 0);
        chk("arb.rd_tuple0", bus.upd_tuple, 0);
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk("arb.idle1", bus.state, 0);
        chk("arb.rd_key0", bus.rd_key, 0);
        tick();
        chk("arb.upd1", bus.state, 1);
        chk("arb.upd1_bytes", bus.upd_bytes, 16'h00B2);
        bus.upd_ready = 1'b1;
        tick();
        bus.upd_ready = 1'b0;
        tick(3);
        chk("arb.done", bus.state, 0);

        // runt counter saturates at all-ones
        for (int i = 0; i < 8; i++)
            send_pkt(1, 16'h0800, 8'd6, 32'h1, 32'h2, 16'd3, 16'd4, 16'd5);
        chk("runt.sat", bus.runt_cnt, 7);
        chk("drop.kept", bus.drop_cnt, 2);

        // reset with a queued tuple and a partial packet in flight
        send_pkt(2, 16'h0800, 8'd6, 32'h5, 32'h6, 16'd7, 16'd8, 16'h00C3);
        tick();
        chk("rst2.pre", bus.state, 1);
        send_pkt(1, 16'h0800, 8'd6, 32'h0, 32'h0, 16'd9, 16'd9, 16'h0999);
        bus.din = '0;
        bus.din[112:105] = 8'h08;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst2.state", bus.state, 0);
        chk("rst2.upd_valid", bus.upd_valid, 0);
        chk("rst2.tuple", bus.upd_tuple, 0);
        chk("rst2.key", bus.upd_key, 0);
        chk("rst2.drop", bus.drop_cnt, 0);
        chk("rst2.runt", bus.runt_cnt, 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("rst2.qempty", bus.upd_valid, 0);
        send_pkt(2, 16'h0800, 8'd17, 32'hC0A80001, 32'hC0A80002, 16'd1234, 16'd53, 16'h0100);
        wait_upd("rst2.upd");
        chk("rst2.tuple_ok", bus.upd_tuple, {32'hC0A80001, 32'hC0A80002, 16'd1234, 16'd53, 8'd17});
        chk("rst2.bytes", bus.upd_bytes, 16'h0100);
        chk("rst2.key_ok", bus.upd_key, 32'hC0A80003);
        bus.upd_ready = 1'b1;
        tick();
        bus.upd_ready = 1'b0;
        tick(3);
        chk("rst2.single", bus.upd_valid, 0);

        // eth_type filtering
        send_pkt(2, 16'h86DD, 8'd17, 32'h1, 32'h2, 16'd3, 16'd4, 16'h0DD6);
`ifdef SKETCH_IPV4_FILTER_EN
        tick(4);
        chk("flt.v6_drop", bus.upd_valid, 0);
`else
        take_upd("flt.v6_pass", 16'h0DD6);
`endif
        send_pkt(2, 16'h0800, 8'd17, 32'h1, 32'h2, 16'd3, 16'd4, 16'h0800);
        take_upd("flt.v4", 16'h0800);
        chk("flt.drop", bus.drop_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
